// File: rtl/issue_pkg.sv
// Shared constants and types for the issue scheduler and its picker.
package issue_pkg;

  localparam int NUM_ENTRIES = 64;
  localparam int NUM_FU      = 3;
  localparam int IDX_W       = $clog2(NUM_ENTRIES);

  typedef logic [1:0]       fu_code_t;
  typedef logic [IDX_W-1:0] idx_t;

  // FU encodings carried in entry_fu; NONE never matches a real unit.
  localparam fu_code_t FU_ALU0 = 2'd0;
  localparam fu_code_t FU_ALU1 = 2'd1;
  localparam fu_code_t FU_MEM  = 2'd2;
  localparam fu_code_t FU_NONE = 2'd3;

  // Per-unit scoreboard state.
  typedef enum logic {
    FU_IDLE = 1'b0,
    FU_BUSY = 1'b1
  } fu_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: returns the first set request bit
// found when scanning upward from the start pointer, wrapping past the top.
module rr_priority_picker
  import issue_pkg::*;
#(
  parameter int REQ_W = NUM_ENTRIES,
  parameter int PTR_W = $clog2(REQ_W)
) (
  input  logic [REQ_W-1:0] req,
  input  logic [PTR_W-1:0] start,
  output logic             gnt_valid,
  output logic [PTR_W-1:0] gnt_idx
);

  logic [PTR_W:0] pos;

  // Scan offsets from farthest to nearest so the nearest request overwrites the rest.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = '0;
    for (int off = REQ_W - 1; off >= 0; off--) begin
      pos = {1'b0, start} + (PTR_W + 1)'(off);
      if (pos >= (PTR_W + 1)'(REQ_W)) begin
        pos = pos - (PTR_W + 1)'(REQ_W);
      end
      if (req[pos[PTR_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = pos[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Issue-queue select-and-grant: one round-robin pick per functional unit,
// registered grants and clear mask, and the FU busy scoreboard.
module issue_scheduler
  import issue_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_ENTRIES-1:0]    entry_valid,
  input  logic [NUM_ENTRIES-1:0]    entry_ready,
  input  logic [2*NUM_ENTRIES-1:0]  entry_fu,
  input  logic [NUM_FU-1:0]         fu_done,
  input  logic                      flush,
  output logic [NUM_FU-1:0]         issue_valid,
  output logic [IDX_W*NUM_FU-1:0]   issue_index,
  output logic [NUM_ENTRIES-1:0]    issue_clear,
  output logic [NUM_FU-1:0]         fu_busy
);

  logic [NUM_FU-1:0][NUM_ENTRIES-1:0] req;
  logic [NUM_FU-1:0]                  pick_valid;
  logic [NUM_FU-1:0][IDX_W-1:0]       pick_idx;
  logic [NUM_FU-1:0]                  fu_eligible;
  logic [NUM_FU-1:0]                  grant;

  logic [NUM_FU-1:0]            issue_valid_q, issue_valid_d;
  logic [NUM_FU-1:0][IDX_W-1:0] issue_index_q, issue_index_d;
  logic [NUM_ENTRIES-1:0]       issue_clear_q, issue_clear_d;
  logic [NUM_FU-1:0][IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  fu_state_t                    fu_state_q [NUM_FU];
  fu_state_t                    fu_state_d [NUM_FU];

  // Build per-FU request vectors; entries granted last cycle stay masked
  // until the queue has retired them.
  always_comb begin
    req = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        req[k][i] = entry_valid[i] & entry_ready[i] & ~issue_clear_q[i]
                    & (entry_fu[2*i +: 2] == fu_code_t'(k));
      end
    end
  end

  // One rotating picker per functional unit, plus its eligibility term.
  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
      rr_priority_picker #(
        .REQ_W (NUM_ENTRIES),
        .PTR_W (IDX_W)
      ) u_picker (
        .req       (req[gi]),
        .start     (rr_ptr_q[gi]),
        .gnt_valid (pick_valid[gi]),
        .gnt_idx   (pick_idx[gi])
      );

      // A unit finishing this cycle can take a new op at the same edge.
      assign fu_eligible[gi] = (fu_state_q[gi] == FU_IDLE) | fu_done[gi];
    end
  endgenerate

  // Grant decision, pointer advance, clear mask and FU state transitions.
  always_comb begin
    grant         = '0;
    issue_valid_d = '0;
    issue_index_d = issue_index_q;
    issue_clear_d = '0;
    rr_ptr_d      = rr_ptr_q;
    for (int k = 0; k < NUM_FU; k++) begin
      fu_state_d[k] = fu_state_q[k];
    end
    for (int k = 0; k < NUM_FU; k++) begin
      grant[k] = pick_valid[k] & fu_eligible[k] & ~flush;
      if (grant[k]) begin
        issue_valid_d[k]            = 1'b1;
        issue_index_d[k]            = pick_idx[k];
        issue_clear_d[pick_idx[k]]  = 1'b1;
        rr_ptr_d[k]                 = (pick_idx[k] == IDX_W'(NUM_ENTRIES - 1))
                                      ? '0 : pick_idx[k] + IDX_W'(1);
        fu_state_d[k]               = FU_BUSY;
      end else if (fu_done[k]) begin
        // In-flight ops still retire through flush; done while idle is harmless.
        fu_state_d[k] = FU_IDLE;
      end
    end
  end

  // State and output registers; reset drops pending grants immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_valid_q <= '0;
      issue_index_q <= '0;
      issue_clear_q <= '0;
      rr_ptr_q      <= '0;
      for (int k = 0; k < NUM_FU; k++) begin
        fu_state_q[k] <= FU_IDLE;
      end
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_index_q <= issue_index_d;
      issue_clear_q <= issue_clear_d;
      rr_ptr_q      <= rr_ptr_d;
      for (int k = 0; k < NUM_FU; k++) begin
        fu_state_q[k] <= fu_state_d[k];
      end
    end
  end

  // Busy flags decode straight from the registered unit state.
  always_comb begin
    fu_busy = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      fu_busy[k] = (fu_state_q[k] == FU_BUSY);
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_index = issue_index_q;
  assign issue_clear = issue_clear_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: stimulus pushes expected grants,
// a negedge monitor pops and compares whenever a grant appears.
module tb_issue_scheduler;
  import issue_pkg::*;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_ENTRIES-1:0]   entry_valid;
  logic [NUM_ENTRIES-1:0]   entry_ready;
  logic [2*NUM_ENTRIES-1:0] entry_fu;
  logic [NUM_FU-1:0]        fu_done;
  logic                     flush;
  logic [NUM_FU-1:0]        issue_valid;
  logic [IDX_W*NUM_FU-1:0]  issue_index;
  logic [NUM_ENTRIES-1:0]   issue_clear;
  logic [NUM_FU-1:0]        fu_busy;

  typedef struct packed {
    logic [NUM_FU-1:0]            v;
    logic [NUM_FU-1:0][IDX_W-1:0] idx;
    logic [NUM_ENTRIES-1:0]       clr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  issue_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .entry_valid (entry_valid),
    .entry_ready (entry_ready),
    .entry_fu    (entry_fu),
    .fu_done     (fu_done),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_index (issue_index),
    .issue_clear (issue_clear),
    .fu_busy     (fu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // Queue an expected grant; clear mask is one bit per granted index.
  task automatic expect_grant(input logic [2:0] v, input int i0, input int i1, input int i2);
    exp_t e;
    e.v      = v;
    e.idx[0] = IDX_W'(i0);
    e.idx[1] = IDX_W'(i1);
    e.idx[2] = IDX_W'(i2);
    e.clr    = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (v[k]) e.clr[e.idx[k]] = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int i, input logic [1:0] fu);
    entry_valid[i]      = 1'b1;
    entry_ready[i]      = 1'b1;
    entry_fu[2*i +: 2]  = fu;
  endtask

  task automatic drop(input int i);
    entry_valid[i] = 1'b0;
  endtask

  // Monitor: any grant must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (issue_valid !== '0) begin
        $display("[TB] grant valid=%b idx0=%0d idx1=%0d idx2=%0d busy=%b", issue_valid,
                 issue_index[0 +: IDX_W], issue_index[IDX_W +: IDX_W],
                 issue_index[2*IDX_W +: IDX_W], fu_busy);
        if (sb.size() == 0) begin
          check("unexpected_grant", 64'(issue_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("issue_valid", 64'(issue_valid), 64'(mon_e.v));
          for (int k = 0; k < NUM_FU; k++) begin
            if (mon_e.v[k]) begin
              check($sformatf("issue_index%0d", k), 64'(issue_index[IDX_W*k +: IDX_W]),
                    64'(mon_e.idx[k]));
            end
          end
          check("issue_clear", issue_clear, mon_e.clr);
        end
      end else if (issue_clear !== '0) begin
        check("stray_clear", issue_clear, 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    flush       = 1'b0;
    fu_done     = '0;
    entry_valid = '0;
    entry_ready = '0;
    entry_fu    = '0;

    // Reset with a live request driven: everything must stay zero.
    set_entry(5, FU_ALU0);
    repeat (3) tick();
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_issue_index", 64'(issue_index), 64'd0);
    check("rst_issue_clear", issue_clear, 64'd0);
    check("rst_fu_busy", 64'(fu_busy), 64'd0);

    // Single grant after release.
    reset_n = 1'b1;
    expect_grant(3'b001, 5, 0, 0);
    tick();
    check("busy_after_grant5", 64'(fu_busy), 64'b001);
    drop(5);
    fu_done = 3'b001;
    tick();
    fu_done = '0;
    check("busy_after_done0", 64'(fu_busy), 64'b000);

    // Round robin on FU1 across entries 2, 7, 9 then 2 again.
    set_entry(2, FU_ALU1); set_entry(7, FU_ALU1); set_entry(9, FU_ALU1);
    expect_grant(3'b010, 0, 2, 0);
    tick();
    drop(2);
    fu_done = 3'b010;
    expect_grant(3'b010, 0, 7, 0);
    tick();
    drop(7);
    expect_grant(3'b010, 0, 9, 0);
    tick();
    drop(9);
    entry_valid[2] = 1'b1;
    expect_grant(3'b010, 0, 2, 0);
    tick();
    drop(2);
    tick();
    fu_done = '0;

    // Wrap: pointer at 3, entries 63 and 0 -> 63 first, then 0.
    set_entry(63, FU_ALU1); set_entry(0, FU_ALU1);
    expect_grant(3'b010, 0, 63, 0);
    tick();
    drop(63);
    fu_done = 3'b010;
    expect_grant(3'b010, 0, 0, 0);
    tick();
    drop(0);
    tick();
    fu_done = '0;

    // All three units in the same cycle.
    set_entry(3, FU_ALU0); set_entry(4, FU_ALU1); set_entry(5, FU_MEM);
    expect_grant(3'b111, 3, 4, 5);
    tick();
    drop(3); drop(4); drop(5);
    fu_done = 3'b111;
    tick();
    fu_done = '0;

    // Busy FU0 blocks entry 1 until a done pulse.
    set_entry(10, FU_ALU0);
    expect_grant(3'b001, 10, 0, 0);
    tick();
    drop(10);
    set_entry(1, FU_ALU0);
    tick();
    tick();
    check("busy_blocking", 64'(fu_busy), 64'b001);
    fu_done = 3'b001;
    expect_grant(3'b001, 1, 0, 0);
    tick();
    fu_done = '0;
    check("busy_done_and_grant", 64'(fu_busy), 64'b001);
    drop(1);
    fu_done = 3'b001;
    tick();
    fu_done = '0;
    check("busy_released", 64'(fu_busy), 64'b000);

    // Entry held valid an extra cycle is granted once; fu code 3 never is.
    set_entry(6, FU_ALU0);
    set_entry(20, FU_NONE);
    expect_grant(3'b001, 6, 0, 0);
    tick();
    fu_done = 3'b001;
    tick();
    fu_done = '0;
    drop(6);
    tick();
    tick();
    check("busy_after_single6", 64'(fu_busy), 64'b000);

    // Flush with a request sampled: no grant, busy untouched.
    set_entry(12, FU_MEM);
    expect_grant(3'b100, 0, 0, 12);
    tick();
    drop(12);
    set_entry(13, FU_ALU0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_issue_valid", 64'(issue_valid), 64'd0);
    check("flush_fu_busy", 64'(fu_busy), 64'b100);
    expect_grant(3'b001, 13, 0, 0);
    tick();
    check("busy_two_units", 64'(fu_busy), 64'b101);
    drop(13);

    // Asynchronous reset mid-busy clears state without a clock edge.
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_fu_busy", 64'(fu_busy), 64'd0);
    check("async_rst_issue_valid", 64'(issue_valid), 64'd0);
    check("async_rst_issue_clear", issue_clear, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
